// File: rtl/vga_timing_out_pkg.sv
// Shared constants and types for the VGA raster timing / output stage.
// Holds the 1280x1024@60 timing set and the default background colour.
`timescale 1ns/1ps
package vga_timing_out_pkg;

    localparam logic [23:0] COLOR_BACKGROUND = 24'h000000;

    localparam int VGA_1280X1024_H_VISIBLE = 1280;
    localparam int VGA_1280X1024_H_FP      = 48;
    localparam int VGA_1280X1024_H_SYNC    = 112;
    localparam int VGA_1280X1024_H_BP      = 248;
    localparam int VGA_1280X1024_V_VISIBLE = 1024;
    localparam int VGA_1280X1024_V_FP      = 1;
    localparam int VGA_1280X1024_V_SYNC    = 3;
    localparam int VGA_1280X1024_V_BP      = 38;

    // Timing signals as carried through the delay line; syncs already at pin polarity.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_out_delay_line.sv
// Fixed-depth shift register with synchronous reset to RESET_VAL.
// DEPTH = 0 degenerates to a plain wire.
`timescale 1ns/1ps
module vga_timing_out_delay_line #(
    parameter int              WIDTH     = 1,
    parameter int              DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] delayed
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign delayed = sample;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] stages;

        always_ff @(posedge clk) begin
            if (rst) begin
                stages <= {DEPTH{RESET_VAL}};
            end else begin
                stages[0] <= sample;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign delayed = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_out.sv
// Raster counters, sync generation and registered RGB output for the video path.
// HS/VS/DE are delayed by DRAW_LATENCY so they line up with draw_field's colour.
`timescale 1ns/1ps
module vga_timing_out
    import vga_timing_out_pkg::*;
#(
    parameter int          PIX_WIDTH    = 12,
    parameter int          H_VISIBLE    = VGA_1280X1024_H_VISIBLE,
    parameter int          H_FP         = VGA_1280X1024_H_FP,
    parameter int          H_SYNC       = VGA_1280X1024_H_SYNC,
    parameter int          H_BP         = VGA_1280X1024_H_BP,
    parameter int          V_VISIBLE    = VGA_1280X1024_V_VISIBLE,
    parameter int          V_FP         = VGA_1280X1024_V_FP,
    parameter int          V_SYNC       = VGA_1280X1024_V_SYNC,
    parameter int          V_BP         = VGA_1280X1024_V_BP,
    parameter bit          SYNC_POL     = 1'b1,
    parameter int          DRAW_LATENCY = 2,
    parameter logic [23:0] BG_COLOR     = COLOR_BACKGROUND
) (
    input  logic                 clk,
    input  logic                 rst_i,
    output logic [PIX_WIDTH-1:0] pix_x_o,
    output logic [PIX_WIDTH-1:0] pix_y_o,
    output logic                 pix_visible_o,
    output logic                 vblank_start_o,
    input  logic [23:0]          draw_data_i,
    input  logic                 draw_data_en_i,
    output logic [23:0]          vga_rgb_o,
    output logic                 vga_hs_o,
    output logic                 vga_vs_o,
    output logic                 vga_de_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [2:0] DELAY_RESET = {~SYNC_POL, ~SYNC_POL, 1'b0};

    if ((2 ** PIX_WIDTH) < H_TOTAL || (2 ** PIX_WIDTH) < V_TOTAL) begin : g_bad_width
        $error("vga_timing_out: PIX_WIDTH too small for H_TOTAL/V_TOTAL");
    end
    if (DRAW_LATENCY < 0 || DRAW_LATENCY > 8) begin : g_bad_latency
        $error("vga_timing_out: DRAW_LATENCY must be 0..8");
    end

    logic [PIX_WIDTH-1:0] h_cnt, v_cnt;
    logic [PIX_WIDTH-1:0] h_next, v_next;
    logic [31:0]          h_ext, v_ext;
    logic                 h_last, v_last;
    logic                 hs_raw, vs_raw;
    sync_t                raw, delayed;

    assign h_ext  = 32'(h_cnt);
    assign v_ext  = 32'(v_cnt);
    assign h_last = (h_ext == 32'(H_TOTAL - 1));
    assign v_last = (v_ext == 32'(V_TOTAL - 1));

    always_comb begin
        h_next = h_last ? '0 : h_cnt + PIX_WIDTH'(1);
        v_next = v_cnt;
        if (h_last) begin
            v_next = v_last ? '0 : v_cnt + PIX_WIDTH'(1);
        end
    end

    // vblank_start is decoded from the next counter values so it is high
    // in the same cycle the counters show (0, V_VISIBLE).
    always_ff @(posedge clk) begin
        if (rst_i) begin
            h_cnt          <= '0;
            v_cnt          <= '0;
            vblank_start_o <= 1'b0;
        end else begin
            h_cnt          <= h_next;
            v_cnt          <= v_next;
            vblank_start_o <= (h_next == '0) && (32'(v_next) == 32'(V_VISIBLE));
        end
    end

    assign pix_x_o       = h_cnt;
    assign pix_y_o       = v_cnt;
    assign pix_visible_o = (h_ext < 32'(H_VISIBLE)) && (v_ext < 32'(V_VISIBLE));

    assign hs_raw = (h_ext >= 32'(H_VISIBLE + H_FP)) && (h_ext < 32'(H_VISIBLE + H_FP + H_SYNC));
    assign vs_raw = (v_ext >= 32'(V_VISIBLE + V_FP)) && (v_ext < 32'(V_VISIBLE + V_FP + V_SYNC));

    always_comb begin
        raw.hs = sync_level(hs_raw, SYNC_POL);
        raw.vs = sync_level(vs_raw, SYNC_POL);
        raw.de = pix_visible_o;
    end

    vga_timing_out_delay_line #(
        .WIDTH    (3),
        .DEPTH    (DRAW_LATENCY),
        .RESET_VAL(DELAY_RESET)
    ) u_delay (
        .clk    (clk),
        .rst    (rst_i),
        .sample (raw),
        .delayed(delayed)
    );

    // Draw inputs only reach the RGB register while delayed DE is high.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            vga_rgb_o <= '0;
            vga_de_o  <= 1'b0;
            vga_hs_o  <= ~SYNC_POL;
            vga_vs_o  <= ~SYNC_POL;
        end else begin
            vga_de_o  <= delayed.de;
            vga_hs_o  <= delayed.hs;
            vga_vs_o  <= delayed.vs;
            vga_rgb_o <= delayed.de ? (draw_data_en_i ? draw_data_i : BG_COLOR) : 24'h0;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out on a 14x8 raster: four instances (latency 0/2/4, and
// latency 2 with active-low syncs) checked every cycle against a raster model.
`timescale 1ns/1ps
module tb_vga_timing_out;

    localparam int N_DUT = 4;
    localparam int HV = 8, HFP = 2, HSY = 3, HBP = 1;
    localparam int VV = 4, VFP = 1, VSY = 2, VBP = 1;
    localparam int H_TOT = HV + HFP + HSY + HBP;
    localparam int V_TOT = VV + VFP + VSY + VBP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam logic [23:0] BG = 24'h3C5A7E;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 0;
            1:       return 2;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic bit pol_of(input int g);
        return g != 3;
    endfunction

    typedef struct packed {
        logic [3:0]  x;
        logic [3:0]  y;
        logic        vis;
        logic        vbl;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;
    typedef exp_t [N_DUT-1:0] exp_vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [23:0] draw_data = '0;
    logic        draw_en = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       px  [N_DUT];
    logic [3:0]       py  [N_DUT];
    logic [23:0]      rgb [N_DUT];
    logic [N_DUT-1:0] vis, vbl, hs, vs, de;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        vga_timing_out #(
            .PIX_WIDTH   (4),
            .H_VISIBLE   (HV),
            .H_FP        (HFP),
            .H_SYNC      (HSY),
            .H_BP        (HBP),
            .V_VISIBLE   (VV),
            .V_FP        (VFP),
            .V_SYNC      (VSY),
            .V_BP        (VBP),
            .SYNC_POL    (pol_of(g)),
            .DRAW_LATENCY(lat_of(g)),
            .BG_COLOR    (BG)
        ) u_dut (
            .clk           (clk),
            .rst_i         (rst),
            .pix_x_o       (px[g]),
            .pix_y_o       (py[g]),
            .pix_visible_o (vis[g]),
            .vblank_start_o(vbl[g]),
            .draw_data_i   (draw_data),
            .draw_data_en_i(draw_en),
            .vga_rgb_o     (rgb[g]),
            .vga_hs_o      (hs[g]),
            .vga_vs_o      (vs[g]),
            .vga_de_o      (de[g])
        );
    end

    // Reference: cycle t after reset shows raster position (t mod H_TOT, t div H_TOT mod V_TOT);
    // video pins show the position from lat+1 cycles earlier, nothing from before reset.
    function automatic exp_t model(input int t, input int lat, input bit pol, input bit in_rst,
                                   input logic [23:0] data, input logic en);
        exp_t e;
        int x, y, s, sx, sy;
        bit a_de, a_hs, a_vs;
        x = t % H_TOT;
        y = (t / H_TOT) % V_TOT;
        e.x   = 4'(x);
        e.y   = 4'(y);
        e.vis = (x < HV) && (y < VV);
        e.vbl = !in_rst && (x == 0) && (y == VV);
        s = t - lat - 1;
        a_de = 1'b0;
        a_hs = 1'b0;
        a_vs = 1'b0;
        if (!in_rst && s >= 0) begin
            sx = s % H_TOT;
            sy = (s / H_TOT) % V_TOT;
            a_de = (sx < HV) && (sy < VV);
            a_hs = (sx >= HV + HFP) && (sx < HV + HFP + HSY);
            a_vs = (sy >= VV + VFP) && (sy < VV + VFP + VSY);
        end
        e.de  = a_de;
        e.hs  = a_hs ? pol : !pol;
        e.vs  = a_vs ? pol : !pol;
        e.rgb = a_de ? (en ? data : BG) : 24'h0;
        return e;
    endfunction

    // scoreboard
    exp_vec_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int t = 0;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    // driver: drive one cycle of inputs and push the expected outputs of the next cycle
    task automatic step(input bit r);
        exp_vec_t ev;
        int t_next;
        @(negedge clk);
        rst = r;
        case ($urandom_range(0, 3))
            0:       draw_data = 24'hFF0000;
            1:       draw_data = 24'hFFFFFF;
            default: draw_data = 24'($urandom());
        endcase
        draw_en = 1'($urandom_range(0, 1));
        t_next = r ? 0 : t + 1;
        for (int g = 0; g < N_DUT; g++) begin
            ev[g] = model(t_next, lat_of(g), pol_of(g), r, draw_data, draw_en);
        end
        exp_q.push_back(ev);
        t = t_next;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // monitor
    initial begin
        exp_vec_t ev;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                for (int g = 0; g < N_DUT; g++) begin
                    chk("pix_x", g, 32'(px[g]), 32'(ev[g].x));
                    chk("pix_y", g, 32'(py[g]), 32'(ev[g].y));
                    chk("pix_visible", g, 32'(vis[g]), 32'(ev[g].vis));
                    chk("vblank_start", g, 32'(vbl[g]), 32'(ev[g].vbl));
                    chk("vga_rgb", g, 32'(rgb[g]), 32'(ev[g].rgb));
                    chk("vga_hs", g, 32'(hs[g]), 32'(ev[g].hs));
                    chk("vga_vs", g, 32'(vs[g]), 32'(ev[g].vs));
                    chk("vga_de", g, 32'(de[g]), 32'(ev[g].de));
                end
            end
        end
    end

    // stimulus
    initial begin
        int waited;
        for (int i = 0; i < 3; i++) step(1'b1);
        run(2 * FRAME + 10);
        // single-clock reset with the counters at (6,2)
        for (int i = 0; i < FRAME && (t % FRAME) != (2 * H_TOT + 6); i++) step(1'b0);
        step(1'b1);
        run(FRAME + 40);
        for (int k = 0; k < 3; k++) begin
            run($urandom_range(20, 200));
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b1);
        end
        run(2 * FRAME + 30);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Raster timing generator and output stage for the tetris video path.
- Produces pixel coordinates for draw_field, and delays HS/VS/DE to match the draw path latency.
- Registers draw_field's colour/enable into the final RGB, substituting background outside drawn regions and black in blanking.
- Emits a vblank_start pulse so game logic updates game data outside the visible area.

Parameters:
- PIX_WIDTH, 12, width of pixel coordinate/counters; must satisfy 2**PIX_WIDTH >= H_TOTAL and >= V_TOTAL (elaboration assertion).
- H_VISIBLE, 1280, active pixels per line.
- H_FP, 48, horizontal front porch.
- H_SYNC, 112, HS pulse width.
- H_BP, 248, horizontal back porch.
- V_VISIBLE, 1024, active lines.
- V_FP, 1, vertical front porch.
- V_SYNC, 3, VS pulse width.
- V_BP, 38, vertical back porch.
- SYNC_POL, 1, sync active level (1 = active-high, 0 = active-low), applies to HS and VS.
- DRAW_LATENCY, 2, clocks from pix_x_o/pix_y_o to matching draw_data_i/draw_data_en_i; range 0..8.
- BG_COLOR, 24'h000000, colour in visible area where draw_data_en_i is low.

Ports:
- clk  in  1  pixel clock.
- rst_i  in  1  synchronous, active-high reset.
- pix_x_o  out  PIX_WIDTH  current horizontal count, to draw_field pix_x_i.
- pix_y_o  out  PIX_WIDTH  current vertical count, to draw_field pix_y_i.
- pix_visible_o  out  1  high when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- vblank_start_o  out  1  one-clock pulse at h_cnt==0, v_cnt==V_VISIBLE.
- draw_data_i  in  24  colour from draw_field vga_data_o.
- draw_data_en_i  in  1  from draw_field vga_data_en_o.
- vga_rgb_o  out  24  registered pixel colour {R,G,B}.
- vga_hs_o  out  1  horizontal sync, polarity per SYNC_POL.
- vga_vs_o  out  1  vertical sync, polarity per SYNC_POL.
- vga_de_o  out  1  data enable, aligned with vga_rgb_o.

Behaviour:
- Timing totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (1688); V_TOTAL likewise (1066).
- h_cnt increments every clk; it wraps H_TOTAL-1 -> 0.
- v_cnt increments when h_cnt wraps; it wraps V_TOTAL-1 -> 0 at the same edge as h_cnt wraps.
- pix_x_o = h_cnt and pix_y_o = v_cnt, direct register outputs, also during blanking; draw_field ignores out-of-field coordinates.
- Raw sync/enable are combinational from the counters:
  - hs_raw active when H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC.
  - vs_raw active when V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC; vs_raw changes on line boundaries only.
  - de_raw = pix_visible_o.
- hs_raw, vs_raw and de_raw pass through a DRAW_LATENCY-stage delay line. With DRAW_LATENCY = 0 there is no delay.
- Output register, updated every clk:
  - vga_de_o = de_d.
  - vga_hs_o / vga_vs_o = delayed syncs, at active level SYNC_POL.
  - vga_rgb_o = de_d ? (draw_data_en_i ? draw_data_i : BG_COLOR) : 24'h0.
- Latency: counters at cycle t appear on vga_* at edge t+DRAW_LATENCY+1. Total latency is identical for rgb, de, hs and vs.
- vblank_start_o is registered: it is high for the cycle in which (h_cnt, v_cnt) == (0, V_VISIBLE), undelayed. Exactly one pulse per frame.
- Reset, at start-up or mid-frame:
  - h_cnt = v_cnt = 0.
  - All delay stages cleared to the inactive state (de 0, syncs at ~SYNC_POL).
  - vga_rgb_o = 0, vga_de_o = 0, vga_hs_o = vga_vs_o = inactive, vblank_start_o = 0.
  - After release, counting restarts at (0,0). vga_de_o first rises DRAW_LATENCY+1 clocks later.
  - No partial sync pulse is carried across reset.
- draw_data_i is sampled only while de_d is high; X on draw inputs in blanking must not propagate to vga_rgb_o.

Decomposition:
- defs.vh additions:
  - `COLOR_BACKGROUND, used as the top-level BG_COLOR value.
  - `VGA_1280x1024_* timing constants for top-level overrides.
- Sub-module delay_line:
  - Parameters WIDTH and DEPTH; DEPTH = 0 is a passthrough.
  - Synchronous reset to a parameter RESET_VAL.
  - Instantiated once with WIDTH=3 for {hs, vs, de}.

Test Plan:
- Small timing: H 8/2/3/1 (total 14), V 4/1/2/1 (total 8), DRAW_LATENCY=2, SYNC_POL=1.
  - Counter wrap: after reset, pix_x_o runs 0..13,0 and pix_y_o steps 0..7,0 at each x wrap.
  - Frame period: exactly 112 clks between frame repeats.
- Sync alignment: HS counters at h=10..12 -> vga_hs_o high for 3 clks, 3 clks later (h=13,0,1 of counter time). VS high for 2 full lines starting at v=5, also delayed 3 clks.
- Colour mux:
  - draw_data_en_i=1, draw_data_i=24'hFF0000 during visible -> vga_rgb_o=FF0000 with vga_de_o=1.
  - draw_data_en_i=0 -> BG_COLOR.
  - In blanking with draw_data_i=24'hFFFFFF, en=1 -> vga_rgb_o=0.
- Latency sweep: DRAW_LATENCY=0 and 4. A scoreboard predicts vga_de_o rising exactly DRAW_LATENCY+1 clks after pix (0,0) following reset.
- vblank_start_o: pulses once per frame at (0,4) in small timing; never asserted during reset.
- Mid-frame reset: rst_i asserted at (6,2) for 1 clk.
  - During the reset clock's output: all outputs inactive, syncs at ~SYNC_POL.
  - Counters restart at (0,0); no glitch pulse on vga_hs_o/vga_vs_o.
  - SYNC_POL=0 variant checks the idle level is 1.
